// File: rtl/ifpad_ring.sv
// ifpad_ring: input-feature scratchpad for one PE. It is a circular buffer of Depth pixels that
// holds a sliding window of L pixels.
//   - Write side: pixels stream in on a valid/ready handshake (i_ipix_*, o_ipix_ready).
//   - Read side: o_opix_* replays the window to the XBU. i_rewind restarts the replay, and
//     i_pop retires U entries from the head.
//   - Pops larger than the occupancy enter SKIP. SKIP discards the pixels that the window
//     already stepped over.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_start, i_clear      configure+start (from IDLE), synchronous flush
//   i_cfg_len, i_cfg_pop  window length L, retire stride U
//   i_pop, i_rewind       retire-and-restart, restart-only pulses
//   i_ipix_*/o_ipix_ready input pixel stream
//   o_opix_*/i_opix_ready output pixel stream (data, zero flag, last-of-window)
//   o_count, o_busy, o_err occupancy, state != IDLE, sticky error
module ifpad_ring #(
  parameter int unsigned DWd    = 16,
  parameter int unsigned Depth  = 16,
  parameter int unsigned AddrWd = $clog2(Depth),
  parameter int unsigned LenWd  = AddrWd + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [LenWd-1:0] i_cfg_len,
  input  logic [LenWd-1:0] i_cfg_pop,
  input  logic             i_pop,
  input  logic             i_rewind,
  input  logic [DWd-1:0]   i_ipix_data,
  input  logic             i_ipix_zero,
  input  logic             i_ipix_valid,
  output logic             o_ipix_ready,
  output logic [DWd-1:0]   o_opix_data,
  output logic             o_opix_zero,
  output logic             o_opix_last,
  output logic             o_opix_valid,
  input  logic             i_opix_ready,
  output logic [LenWd-1:0] o_count,
  output logic             o_busy,
  output logic             o_err
);

  typedef enum logic [1:0] {StIdle, StActive, StSkip} state_e;

  localparam logic [LenWd-1:0] DepthL = LenWd'(Depth);

  state_e             state_q, state_d;
  logic [AddrWd-1:0]  base_q, base_d, wptr_q, wptr_d;
  logic [LenWd-1:0]   count_q, count_d, offset_q, offset_d, deficit_q, deficit_d;
  logic [LenWd-1:0]   len_q, len_d, pop_q, pop_d;
  logic               err_q, err_d;
  logic [Depth-1:0]   zflag_q, zflag_d;
  logic [DWd-1:0]     mem_q [Depth];

  logic [AddrWd-1:0]  rd_addr;
  logic [LenWd-1:0]   retire;
  logic               wr_fire, rd_fire, mem_we, cfg_ok;

  assign rd_addr = base_q + offset_q[AddrWd-1:0];
  assign retire  = (pop_q < count_q) ? pop_q : count_q;
  assign cfg_ok  = (i_cfg_len != '0) && (i_cfg_len <= DepthL) &&
                   (i_cfg_pop != '0) && (i_cfg_pop <= i_cfg_len);

  always_comb begin
    o_ipix_ready = ((state_q == StActive) && (count_q < DepthL)) || (state_q == StSkip);
    o_opix_valid = (state_q == StActive) && (offset_q < len_q) && (offset_q < count_q);
    o_opix_data  = mem_q[rd_addr];
    o_opix_zero  = o_opix_valid && zflag_q[rd_addr];
    o_opix_last  = o_opix_valid && (offset_q == len_q - LenWd'(1));
    o_count      = count_q;
    o_busy       = (state_q != StIdle);
    o_err        = err_q;
  end

  assign wr_fire = i_ipix_valid && o_ipix_ready;
  assign rd_fire = o_opix_valid && i_opix_ready;
  // Only ACTIVE stores pixels; SKIP swallows them.
  assign mem_we  = wr_fire && (state_q == StActive) && !i_clear;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    offset_d  = offset_q;
    deficit_d = deficit_q;
    len_d     = len_q;
    pop_d     = pop_q;
    err_d     = err_q;
    zflag_d   = zflag_q;

    if (i_clear) begin
      state_d   = StIdle;
      base_d    = '0;
      wptr_d    = '0;
      count_d   = '0;
      offset_d  = '0;
      deficit_d = '0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            if (cfg_ok) begin
              len_d   = i_cfg_len;
              pop_d   = i_cfg_pop;
              err_d   = 1'b0;
              state_d = StActive;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StActive: begin
          if (mem_we) begin
            zflag_d[wptr_q] = i_ipix_zero;
            wptr_d          = wptr_q + AddrWd'(1);
          end
          // Retire amount uses the pre-write count, so a same-cycle write is always kept.
          count_d = count_q + LenWd'(mem_we) - (i_pop ? retire : '0);
          if (i_pop || i_rewind) begin
            offset_d = '0;
          end else if (rd_fire) begin
            offset_d = offset_q + LenWd'(1);
          end
          if (i_pop) begin
            base_d = base_q + retire[AddrWd-1:0];
            if (pop_q > count_q) begin
              deficit_d = pop_q - count_q;
              state_d   = StSkip;
            end
          end
        end
        StSkip: begin
          if (i_pop || i_rewind) begin
            err_d = 1'b1;
          end
          if (wr_fire) begin
            deficit_d = deficit_q - LenWd'(1);
            if (deficit_q == LenWd'(1)) begin
              state_d = StActive;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      base_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      offset_q  <= '0;
      deficit_q <= '0;
      len_q     <= '0;
      pop_q     <= '0;
      err_q     <= 1'b0;
      zflag_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      offset_q  <= offset_d;
      deficit_q <= deficit_d;
      len_q     <= len_d;
      pop_q     <= pop_d;
      err_q     <= err_d;
      zflag_q   <= zflag_d;
    end
  end

  // Pixel storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= i_ipix_data;
    end
  end

endmodule
